// File: rtl/ahbpassthru_slave.sv
// Registered AHB slave that forwards single transfers to an off-chip responder over req/ack,
// holding the bus with wait states and mapping off-chip errors or timeouts to a two-cycle ERROR.
module ahbpassthru_slave #(
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255,
    parameter int TOWIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsel,
    input  logic                 hready,
    input  logic [1:0]           htrans,
    input  logic [31:0]          haddr,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [DATAWIDTH-1:0] hwdata,
    output logic                 hreadyout,
    output logic [1:0]           hresp,
    output logic [DATAWIDTH-1:0] hrdata,
    output logic                 pt_req,
    output logic [31:0]          pt_addr,
    output logic                 pt_write,
    output logic [2:0]           pt_size,
    output logic [DATAWIDTH-1:0] pt_wdata,
    input  logic                 pt_ack,
    input  logic                 pt_err,
    input  logic [DATAWIDTH-1:0] pt_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } state_t;

    localparam logic [TOWIDTH-1:0] TO_LIMIT  = TOWIDTH'(TIMEOUT);
    localparam logic               TO_ENABLE = (TIMEOUT != 0);
    localparam logic [TOWIDTH-1:0] TO_ONE    = {{(TOWIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]         RESP_OKAY = 2'b00;
    localparam logic [1:0]         RESP_ERR  = 2'b01;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [TOWIDTH-1:0]     to_cnt_r;
    logic                   accept_s;
    logic                   timeout_s;
    logic                   hreadyout_next_s;
    logic [1:0]             hresp_next_s;
    logic                   pt_req_next_s;
    logic                   hreadyout_r;
    logic [1:0]             hresp_r;
    logic [DATAWIDTH-1:0]   hrdata_r;
    logic                   pt_req_r;
    logic [31:0]            pt_addr_r;
    logic                   pt_write_r;
    logic [2:0]             pt_size_r;
    logic [DATAWIDTH-1:0]   pt_wdata_r;
    logic                   unused_s;

    // Burst/SEQ distinction is irrelevant: every beat is an independent transfer.
    assign unused_s  = htrans[0];
    assign accept_s  = hsel & hready & htrans[1];
    assign timeout_s = TO_ENABLE & (to_cnt_r == TO_LIMIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; pt_err has priority over pt_ack, and both over the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = accept_s ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_next_s = ST_REQ;
            ST_REQ: begin
                if (pt_err) begin
                    state_next_s = ST_ERR1;
                end else if (pt_ack) begin
                    state_next_s = ST_DONE;
                end else if (timeout_s) begin
                    state_next_s = ST_ERR1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE:  state_next_s = accept_s ? ST_SETUP : ST_IDLE;
            ST_ERR1:  state_next_s = ST_ERR2;
            ST_ERR2:  state_next_s = accept_s ? ST_SETUP : ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the AHB/pt outputs can be registered.
    always_comb begin
        hreadyout_next_s = 1'b1;
        hresp_next_s     = RESP_OKAY;
        pt_req_next_s    = 1'b0;
        case (state_next_s)
            ST_IDLE:  hreadyout_next_s = 1'b1;
            ST_SETUP: hreadyout_next_s = 1'b0;
            ST_REQ: begin
                hreadyout_next_s = 1'b0;
                pt_req_next_s    = 1'b1;
            end
            ST_DONE:  hreadyout_next_s = 1'b1;
            ST_ERR1: begin
                hreadyout_next_s = 1'b0;
                hresp_next_s     = RESP_ERR;
            end
            ST_ERR2: begin
                hreadyout_next_s = 1'b1;
                hresp_next_s     = RESP_ERR;
            end
            default:  hreadyout_next_s = 1'b1;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
            pt_req_r    <= 1'b0;
        end else begin
            hreadyout_r <= hreadyout_next_s;
            hresp_r     <= hresp_next_s;
            pt_req_r    <= pt_req_next_s;
        end
    end

    // Transfer datapath: SETUP is only reachable through an accept, so it doubles as the latch enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_addr_r  <= 32'h0000_0000;
            pt_write_r <= 1'b0;
            pt_size_r  <= 3'b000;
            pt_wdata_r <= {DATAWIDTH{1'b0}};
            hrdata_r   <= {DATAWIDTH{1'b0}};
        end else begin
            if (state_next_s == ST_SETUP) begin
                pt_addr_r  <= haddr;
                pt_write_r <= hwrite;
                pt_size_r  <= hsize;
            end
            if ((state_r == ST_SETUP) && pt_write_r) begin
                pt_wdata_r <= hwdata;
            end
            if ((state_r == ST_REQ) && pt_ack && !pt_err && !pt_write_r) begin
                hrdata_r <= pt_rdata;
            end
        end
    end

    // Timeout counter: held at zero outside REQ, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TOWIDTH{1'b0}};
        end else if (state_r == ST_REQ) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= {TOWIDTH{1'b0}};
        end
    end

    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
    assign hrdata    = hrdata_r;
    assign pt_req    = pt_req_r;
    assign pt_addr   = pt_addr_r;
    assign pt_write  = pt_write_r;
    assign pt_size   = pt_size_r;
    assign pt_wdata  = pt_wdata_r;

endmodule

// File: doc/ahbpassthru_slave.md
# ahbpassthru_slave

Registered AHB slave port that forwards single transfers from the on-chip AHB bus to an off-chip target over a simple request/acknowledge interface. It is the slave-side counterpart of the master pass-through, for traffic flowing from the bus out to an off-chip responder. The block holds the bus with wait states until the off-chip side acknowledges. It converts an off-chip error, or a missing acknowledge after a programmable timeout, into a two-cycle AHB ERROR response.

## Interface

Parameters:
- DATAWIDTH, 32, data bus width
- TIMEOUT, 255, maximum cycles to wait for pt_ack/pt_err in REQ; 0 disables the timeout
- TOWIDTH, 8, timeout counter width; TIMEOUT must fit in TOWIDTH bits

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- hsel  in  1  slave select
- hready  in  1  bus transfer done
- htrans  in  2  transfer type
- haddr  in  32  address
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hwdata  in  DATAWIDTH  write data, valid in the data phase
- hreadyout  out  1  slave ready
- hresp  out  2  response, 00 = OKAY, 01 = ERROR
- hrdata  out  DATAWIDTH  read data
- pt_req  out  1  off-chip request, held until completion
- pt_addr  out  32  latched address
- pt_write  out  1  latched hwrite
- pt_size  out  3  latched hsize
- pt_wdata  out  DATAWIDTH  latched write data
- pt_ack  in  1  off-chip completion, OKAY
- pt_err  in  1  off-chip completion, error
- pt_rdata  in  DATAWIDTH  off-chip read data, valid when pt_ack = 1

## Operation

- Accept condition: hsel & hready & htrans[1], i.e. NONSEQ or SEQ. On accept, latch haddr, hwrite and hsize into pt_addr, pt_write and pt_size.
- hsel with htrans IDLE or BUSY gets a zero-wait OKAY response. No state change.
- FSM states: IDLE, SETUP, REQ, DONE, ERR1, ERR2.
- IDLE: hreadyout = 1, hresp = OKAY. On accept, go to SETUP.
- SETUP: hreadyout = 0. For a write, capture hwdata into pt_wdata. Next state is REQ.
- REQ: pt_req = 1, hreadyout = 0, and the timeout counter increments each cycle.
  - pt_err = 1: go to ERR1. pt_err wins if pt_ack is asserted in the same cycle.
  - pt_ack = 1: for a read, load pt_rdata into hrdata; go to DONE.
  - Counter reaches TIMEOUT with neither pt_ack nor pt_err (TIMEOUT ≠ 0): go to ERR1.
- DONE: hreadyout = 1, hresp = OKAY. On accept, go to SETUP; otherwise go to IDLE.
- ERR1: hreadyout = 0, hresp = ERROR. Next state is ERR2.
- ERR2: hreadyout = 1, hresp = ERROR. On accept, go to SETUP; otherwise go to IDLE.
- pt_req drops in the cycle after pt_ack, pt_err or the timeout. The off-chip side must not hold pt_ack/pt_err after pt_req falls.
- pt_ack and pt_err outside REQ are ignored.
- The timeout counter is cleared on entry to REQ.
- hrdata holds its value until the next read completes. Writes and errors leave it unchanged.
- hsize and htrans burst types are forwarded or ignored without checking. Every beat is an independent transfer.
- Reset values:
  - hreadyout = 1, hresp = 00
  - hrdata = 0
  - pt_req = 0, pt_addr = 0, pt_write = 0, pt_size = 0, pt_wdata = 0
  - FSM = IDLE, counter = 0
- Reset mid-transfer aborts at once. pt_req drops asynchronously. No response is completed.

## Timing

- Minimum transfer: accept at cycle T0, SETUP at T1, REQ with pt_ack at T2, DONE with hreadyout = 1 at T3. That is 2 wait states.
- Each extra REQ cycle adds one wait state.
- Error response: ERR1 (hreadyout = 0) and then ERR2 (hreadyout = 1), both with hresp = ERROR.
- Timeout with TIMEOUT = N: ERR1 begins N+1 cycles after REQ is entered.
- Back-to-back transfers: an accept in DONE or ERR2 enters SETUP in the next cycle. There is no idle gap.
- All outputs are registered, with no combinational path from pt_* inputs to AHB outputs.

## Test plan

- Read 0x4000_0010 with pt_ack in the first REQ cycle and pt_rdata = 0xDEAD_BEEF:
  - pt_req high for 1 cycle with pt_addr = 0x4000_0010, pt_write = 0
  - hreadyout low for 2 cycles, then hrdata = 0xDEAD_BEEF with OKAY
- Write 0x1234_5678 to 0x8000_0004 with hsize = 2 and pt_ack after 5 REQ cycles:
  - pt_wdata = 0x1234_5678, pt_write = 1, pt_size = 2, pt_req held 5 cycles
  - 6 wait states, then OKAY
- pt_err and pt_ack together in REQ: two-cycle ERROR response (0/1 hreadyout pattern); hrdata unchanged.
- TIMEOUT = 4, pt_ack never asserted: ERR1 begins 5 cycles after REQ is entered, then ERR2, then IDLE with hreadyout = 1.
- Back-to-back NONSEQ reads, the second presented in the DONE cycle: second SETUP immediately follows DONE, and both hrdata values are returned in order.
- rst asserted during REQ: pt_req and all outputs reach their reset values asynchronously. After release, a new read completes normally.
